// File: rtl/mret_return_ctrl.sv
// MRET return sequencer: flushes the younger stages, redirects fetch to mepc,
// strobes the mstatus restore, then holds a refill window before the next MRET.
module mret_return_ctrl #(
   parameter int REFILL_CYCLES = 4,
   parameter int XLEN          = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mret_mem_i,
   input  logic            stall_i,
   input  logic            trap_pending_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            mstatus_mpie_i,
   input  logic            redirect_ready_i,
   output logic            flush_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            mstatus_we_o,
   output logic            mie_new_o,
   output logic            mpie_new_o,
   output logic            busy_o
);

   localparam int            CW   = $clog2(REFILL_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(REFILL_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, REFILL} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [XLEN-1:0] target, target_nxt;
   logic            saved_mpie, saved_mpie_nxt;
   logic            handshake;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         target     <= '0;
         saved_mpie <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         target     <= target_nxt;
         saved_mpie <= saved_mpie_nxt;
      end
   end

   // The handshake is checked before the trap so an accepted redirect always
   // completes its mstatus restore.
   assign handshake = (state == REDIRECT) & redirect_ready_i;

   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      target_nxt     = target;
      saved_mpie_nxt = saved_mpie;
      case (state)
         IDLE: begin
            if (mret_mem_i & ~stall_i & ~trap_pending_i) begin
               target_nxt     = {mepc_i[XLEN-1:2], 2'b00};
               saved_mpie_nxt = mstatus_mpie_i;
               state_nxt      = FLUSH;
            end
         end
         FLUSH: state_nxt = trap_pending_i ? IDLE : REDIRECT;
         REDIRECT: begin
            if (handshake) begin
               count_nxt = '0;
               state_nxt = REFILL;
            end else if (trap_pending_i) begin
               state_nxt = IDLE;
            end
         end
         REFILL: begin
            if (count == LAST) begin
               count_nxt = '0;
               state_nxt = IDLE;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign flush_o          = (state == FLUSH);
   assign redirect_valid_o = (state == REDIRECT);
   assign redirect_pc_o    = redirect_valid_o ? target : '0;
   assign mstatus_we_o     = handshake;
   assign mie_new_o        = handshake & saved_mpie;
   assign mpie_new_o       = handshake;
   assign busy_o           = (state != IDLE);

endmodule
